ctrl_pipe: RTL
==============

Name: ctrl_pipe

Overview:
- Parametrised pipelined control unit for the RISC-TOY core.
- Decodes the 5-bit opcode in ID and carries the control bundle through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and generates Stall; squashes the ID instruction on a taken branch.
- Flags illegal opcodes and keeps a saturating stall-cycle counter.

Parameters:
OPW, 5, opcode width; opcodes at or above 23 are illegal
REGW, 5, register-address width
LU_DEPTH, 1, load-use check depth: 1 = compare against EX only; 2 = compare against EX and MEM
CNT_W, 16, stall-counter width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
ID_Valid  input  1  ID holds a real instruction
ID_OpCode  input  OPW  opcode in ID
ID_Ra  input  REGW  source A address
ID_Rb  input  REGW  source B address
ID_RaUsed  input  1  source A is read
ID_RbUsed  input  1  source B is read
ID_Rd  input  REGW  destination address
BranchTaken  input  1  EX resolved a taken branch/jump this cycle
ID_ImmSel  output  2  combinational immediate select for ID
Stall  output  1  hold PC/IF/ID this cycle
EX_Valid, EX_Branch, EX_MemRead, EX_MemWrite, EX_RegWrite, EX_MemtoReg  output  1 each  EX-stage controls
EX_Rd  output  REGW  EX destination
MEM_Valid, MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_MemtoReg  output  1 each  MEM-stage controls
MEM_Rd  output  REGW  MEM destination
WB_RegWrite, WB_MemtoReg  output  1 each  WB-stage controls
WB_Rd  output  REGW  WB destination
IllegalOp  output  1  sticky: an illegal opcode entered EX
StallCnt  output  CNT_W  saturating count of Stall cycles

Behaviour:
- Decode (combinational, ID), by opcode:
  - ImmSel: 0–3 → 01; 4–16 → 00; 17, 18 → 10; 19 → 01; 20 → 10; 21 → 01; 22 → 10; illegal → 00.
  - Branch: 15–18.
  - MemRead and MemtoReg: 19, 20.
  - MemWrite: 21, 22.
  - RegWrite: legal opcodes except 15, 17, 21, 22.
  - Illegal opcodes decode to all controls 0, including RegWrite.
- Reset: asynchronous on RST high. All stage Valid, controls and Rd go to 0; IllegalOp = 0; StallCnt = 0. Stall is combinational and is 0 while the stages are empty.
- Latency: a decoded instruction appears on EX_* 1 cycle after it is in ID, MEM_* after 2 cycles, WB_* after 3.
- Hazard condition:
  - hazEX = ID_Valid & EX_Valid & EX_MemRead & EX_Rd != 0 & ((ID_RaUsed & ID_Ra == EX_Rd) | (ID_RbUsed & ID_Rb == EX_Rd)).
  - hazMEM is the same term against the MEM_* signals; it is included only when LU_DEPTH = 2.
  - Stall = (hazEX | hazMEM) & ~BranchTaken.
- Stall cycle:
  - A bubble enters EX: Valid and all controls 0, Rd 0.
  - The ID instruction is not consumed; upstream holds it.
  - MEM and WB still advance.
- BranchTaken cycle:
  - A bubble enters EX (the ID instruction is squashed).
  - The EX instruction advances to MEM normally.
  - BranchTaken overrides Stall when both occur in the same cycle.
- ID_Valid = 0: a bubble enters EX.
- Register 0 is never a hazard source.
- IllegalOp is set when ID_Valid = 1, the opcode is illegal, and the instruction enters EX (not stalled, not flushed). It is cleared only by RST.
- StallCnt increments on every cycle with Stall = 1 and saturates at 2^CNT_W − 1 with no wrap.
- Reset asserted mid-pipeline clears all in-flight instructions immediately; there is no drain.

Test Plan:
- Reset, then issue ADD (4) with Rd = 3 and ID_Valid = 1 → next cycle EX_Valid = 1, EX_RegWrite = 1, EX_Rd = 3; MEM one cycle later; WB_RegWrite = 1, WB_Rd = 3 on the third cycle.
- LD (19) with Rd = 5, followed by ADD with Ra = 5 and RaUsed = 1 → Stall = 1 for exactly 1 cycle with LU_DEPTH = 1 (2 cycles with LU_DEPTH = 2); a bubble appears in EX; StallCnt = 1 (or 2).
- LD with Rd = 0 followed by a use of R0 → Stall stays 0.
- The load-use hazard case with BranchTaken = 1 in the same cycle → Stall = 0; EX_Valid = 0 next cycle; StallCnt unchanged.
- Opcode 25 with ID_Valid = 1 → EX_Valid = 1 with all controls 0; IllegalOp = 1 and stays 1 until RST.
- CNT_W = 2 with 5 consecutive stall cycles → StallCnt = 3. Assert RST asynchronously mid-stream → all outputs 0 before the next CLK edge.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipelined control unit for the RISC-TOY core.
//
// The unit decodes the ID opcode into a control bundle. It then carries that
// bundle through the EX, MEM and WB pipeline registers. It also detects
// load-use hazards, squashes the ID instruction on a taken branch, flags
// illegal opcodes and counts stall cycles.
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   ID_Valid              ID holds a real instruction
//   ID_OpCode             opcode in ID (values >= 23 are illegal)
//   ID_Ra/ID_Rb           source addresses, qualified by ID_RaUsed/ID_RbUsed
//   ID_Rd                 destination address
//   BranchTaken           EX resolved a taken branch/jump this cycle
//   ID_ImmSel             combinational immediate select for ID
//   Stall                 hold PC/IF/ID this cycle
//   EX_*, MEM_*, WB_*     stage control bundles and destinations
//   IllegalOp             sticky: an illegal opcode entered EX
//   StallCnt              saturating count of Stall cycles
//
// Upstream contract: the ID instruction is consumed on a rising edge only
// when ID_Valid=1, Stall=0 and BranchTaken=0. While Stall=1, upstream must
// present the same instruction again. When BranchTaken=1, the ID instruction
// is dropped.
module ctrl_pipe #(
  parameter int OPW      = 5,
  parameter int REGW     = 5,
  parameter int LU_DEPTH = 1,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_Valid,
  input  logic [OPW-1:0]   ID_OpCode,
  input  logic [REGW-1:0]  ID_Ra,
  input  logic [REGW-1:0]  ID_Rb,
  input  logic             ID_RaUsed,
  input  logic             ID_RbUsed,
  input  logic [REGW-1:0]  ID_Rd,
  input  logic             BranchTaken,
  output logic [1:0]       ID_ImmSel,
  output logic             Stall,
  output logic             EX_Valid,
  output logic             EX_Branch,
  output logic             EX_MemRead,
  output logic             EX_MemWrite,
  output logic             EX_RegWrite,
  output logic             EX_MemtoReg,
  output logic [REGW-1:0]  EX_Rd,
  output logic             MEM_Valid,
  output logic             MEM_MemRead,
  output logic             MEM_MemWrite,
  output logic             MEM_RegWrite,
  output logic             MEM_MemtoReg,
  output logic [REGW-1:0]  MEM_Rd,
  output logic             WB_RegWrite,
  output logic             WB_MemtoReg,
  output logic [REGW-1:0]  WB_Rd,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] StallCnt
);

  // ---------------------------------------------------------------- decode
  logic [31:0] opVal;
  logic        decIllegal;
  logic        decBranch;
  logic        decMemRead;
  logic        decMemWrite;
  logic        decRegWrite;
  logic        decMemtoReg;

  assign opVal = 32'(ID_OpCode);

  always_comb begin
    ID_ImmSel   = 2'b00;
    decIllegal  = 1'b0;
    decBranch   = 1'b0;
    decMemRead  = 1'b0;
    decMemWrite = 1'b0;
    decRegWrite = 1'b0;
    decMemtoReg = 1'b0;
    if (opVal >= 32'd23) begin
      // Illegal opcodes decode to an all-zero bundle; only the flag is set.
      decIllegal = 1'b1;
    end else begin
      if (opVal <= 32'd3) begin
        ID_ImmSel = 2'b01;
      end else if (opVal <= 32'd16) begin
        ID_ImmSel = 2'b00;
      end else begin
        case (opVal)
          32'd17, 32'd18, 32'd20, 32'd22: ID_ImmSel = 2'b10;
          32'd19, 32'd21:                 ID_ImmSel = 2'b01;
          default:                        ID_ImmSel = 2'b00;
        endcase
      end
      decBranch   = (opVal >= 32'd15) && (opVal <= 32'd18);
      decMemRead  = (opVal == 32'd19) || (opVal == 32'd20);
      decMemtoReg = decMemRead;
      decMemWrite = (opVal == 32'd21) || (opVal == 32'd22);
      decRegWrite = !((opVal == 32'd15) || (opVal == 32'd17) ||
                      (opVal == 32'd21) || (opVal == 32'd22));
    end
  end

  // ---------------------------------------------------------------- hazards
  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  logic hazEX;
  logic hazMemTerm;
  logic hazMEM;
  logic enterEx;

  assign hazEX = ID_Valid && EX_Valid && EX_MemRead && (EX_Rd != '0) &&
                 ((ID_RaUsed && (ID_Ra == EX_Rd)) ||
                  (ID_RbUsed && (ID_Rb == EX_Rd)));

  assign hazMemTerm = ID_Valid && MEM_Valid && MEM_MemRead && (MEM_Rd != '0) &&
                      ((ID_RaUsed && (ID_Ra == MEM_Rd)) ||
                       (ID_RbUsed && (ID_Rb == MEM_Rd)));

  // A deeper check covers a load whose data is not forwardable out of MEM.
  assign hazMEM = (LU_DEPTH == 2) ? hazMemTerm : 1'b0;

  // A taken branch squashes ID anyway, so it overrides the stall.
  assign Stall = (hazEX || hazMEM) && !BranchTaken;

  // The ID instruction moves into EX only when it is real, not held and not squashed.
  assign enterEx = ID_Valid && !Stall && !BranchTaken;

  // ---------------------------------------------------------------- EX stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EX_Valid    <= 1'b0;
      EX_Branch   <= 1'b0;
      EX_MemRead  <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_RegWrite <= 1'b0;
      EX_MemtoReg <= 1'b0;
      EX_Rd       <= '0;
    end else if (enterEx) begin
      EX_Valid    <= 1'b1;
      EX_Branch   <= decBranch;
      EX_MemRead  <= decMemRead;
      EX_MemWrite <= decMemWrite;
      EX_RegWrite <= decRegWrite;
      EX_MemtoReg <= decMemtoReg;
      EX_Rd       <= ID_Rd;
    end else begin
      // A stall, a flush or an empty ID all become a bubble in EX.
      EX_Valid    <= 1'b0;
      EX_Branch   <= 1'b0;
      EX_MemRead  <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_RegWrite <= 1'b0;
      EX_MemtoReg <= 1'b0;
      EX_Rd       <= '0;
    end
  end

  // ---------------------------------------------------------------- MEM / WB
  // The downstream stages always advance, including during a stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MEM_Valid    <= 1'b0;
      MEM_MemRead  <= 1'b0;
      MEM_MemWrite <= 1'b0;
      MEM_RegWrite <= 1'b0;
      MEM_MemtoReg <= 1'b0;
      MEM_Rd       <= '0;
      WB_RegWrite  <= 1'b0;
      WB_MemtoReg  <= 1'b0;
      WB_Rd        <= '0;
    end else begin
      MEM_Valid    <= EX_Valid;
      MEM_MemRead  <= EX_MemRead;
      MEM_MemWrite <= EX_MemWrite;
      MEM_RegWrite <= EX_RegWrite;
      MEM_MemtoReg <= EX_MemtoReg;
      MEM_Rd       <= EX_Rd;
      WB_RegWrite  <= MEM_RegWrite;
      WB_MemtoReg  <= MEM_MemtoReg;
      WB_Rd        <= MEM_Rd;
    end
  end

  // ---------------------------------------------------------------- status
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IllegalOp <= 1'b0;
      StallCnt  <= '0;
    end else begin
      if (enterEx && decIllegal) begin
        IllegalOp <= 1'b1;
      end
      if (Stall && (StallCnt != {CNT_W{1'b1}})) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
    end
  end

endmodule
